j1_io_uart: RTL and testbench
=============================

Name: j1_io_uart

Overview:
- Responder on the J1 core's I/O bus: decodes io_rd/io_wr strobes and the byte address on mem_addr, returns read data on io_din, and accepts write data from dout.
- Implements a register-mapped 8N1 UART with 4-deep TX and RX byte FIFOs, giving firmware a serial console and debug link.
- Sits beside the core in the top level; io_din from several responders is OR-combined, so this block drives zero when not selected.

Parameters:
- BASE_ADDR, 16'h1000, byte base address; block claims BASE_ADDR..BASE_ADDR+15, decoded as mem_addr[15:4]==BASE_ADDR[15:4].
- CLKDIV, 16'd434, reset value of DIVISOR (clocks per bit; 50 MHz / 115200).
- FIFO_DEPTH, 4, entries per FIFO; must be a power of two, minimum 2.

Ports:
- clk  in  1  Core clock; all state on rising edge.
- resetq  in  1  Asynchronous active-low reset.
- io_rd  in  1  Single-cycle read strobe from core.
- io_wr  in  1  Single-cycle write strobe from core.
- mem_addr  in  16  Byte address; valid while a strobe is high.
- dout  in  16  Write data; valid with io_wr.
- io_din  out  16  Read data, combinational from mem_addr; 0 when not selected.
- uart_rx  in  1  Serial input, asynchronous; idles high.
- uart_tx  out  1  Serial output; idles high.
- irq  out  1  High while (RX FIFO non-empty & ie_rx) | (TX FIFO empty & ie_tx).

Behaviour:
- Register select: sel = mem_addr[15:4]==BASE_ADDR[15:4]; offset = mem_addr[3:1]. Offsets 0 DATA, 1 STATUS, 2 DIVISOR, 3 CTRL; offsets 4-7 read 0 and ignore writes.
- Read timing: the core captures io_din in the same cycle io_rd is high, so io_din is purely combinational from mem_addr and current state. Read side effects occur on the clock edge that ends that cycle. io_din is also driven for a matching address when io_rd is low, but side effects occur only with io_rd high.
- DATA read: {rx_nonempty, 7'b0, rx_head[7:0]}. When io_rd is high and the RX FIFO is non-empty, pop. Reading an empty FIFO returns 16'h0000 and has no effect.
- DATA write: push dout[7:0] to the TX FIFO. If the TX FIFO is full, drop the byte and set sticky tx_ovf.
- STATUS read: bit0 rx_nonempty; bit1 tx_notfull; bit2 tx_idle (FIFO empty and shifter idle); bit3 rx_ovf; bit4 tx_ovf; bit5 frame_err; others 0. STATUS write: writing 1 to bits 3/4/5 clears that sticky bit. If a clear and a set occur in the same cycle, set wins.
- DIVISOR: R/W, 16 bits. Effective bit period is max(DIVISOR,4) clocks. A write takes effect at the next bit-counter reload and does not restart the current bit.
- CTRL: bit0 ie_rx, bit1 ie_tx, bit2 loopback (internal rx = uart_tx; uart_tx pin still drives). Reset value 0.
- TX FSM IDLE->START->DATA(8, LSB first)->STOP->IDLE; each state lasts one bit period.
  - In IDLE with the FIFO non-empty: pop and enter START on the next clock.
  - Back-to-back bytes: STOP goes directly to START if the FIFO is non-empty.
- RX path: 2-flop synchroniser feeds the FSM IDLE->START->DATA->STOP.
  - IDLE: a falling edge loads the counter with period/2.
  - START: at mid-bit, if the line is high, return to IDLE (glitch rejected, no error).
  - DATA: sample 8 bits at mid-bit.
  - STOP: at the stop-bit mid-point, sample once. High: push the byte. Low: discard the byte and set frame_err. Return to IDLE immediately so the next start edge is seen.
- RX FIFO full: the new byte is dropped and rx_ovf is set. A push and a pop on a full FIFO in the same cycle both succeed and do not set rx_ovf.
- TX FIFO: a push while full is dropped. A push and a pop in the same cycle on a full FIFO both succeed.
- Reset values: uart_tx=1, io_din=0 (no select), irq=0, FIFOs empty, all sticky bits 0, DIVISOR=CLKDIV, CTRL=0, both FSMs IDLE.
  - Reset asserted mid-frame forces uart_tx high immediately (asynchronous).
  - A partial RX byte is discarded.

Decomposition:
- Package j1_io_uart_pkg: register offset constants (DATA/STATUS/DIVISOR/CTRL), STATUS and CTRL bit indices, TX/RX FSM state encodings, minimum divisor constant 4.
- Sub-module j1_byte_fifo: parameterised synchronous FIFO with push/pop/full/empty/head and simultaneous push+pop at full. Instantiated twice.

Test Plan:
- Reset, then read STATUS at 16'h1002 -> io_din=16'h0006; uart_tx=1; DIVISOR reads 434.
- Write DIVISOR=8, write DATA=16'h00A5 -> line low 8 clks, then bits 1,0,1,0,0,1,0,1 at 8 clks each, high stop; tx_idle=1 after 80 clks.
- Set loopback, write 0x3C then 0x81 -> two DATA reads return 16'h803C then 16'h8081; a third read returns 16'h0000.
- With DIVISOR=8, drive 6 external bytes with no reads -> first 4 retained, STATUS bit3=1; write STATUS=16'h0008 -> bit3=0.
- Drive a frame with stop bit low -> no push, STATUS bit5=1. Drive a 2-clock low glitch -> no push, no error.
- Fill TX FIFO with 5 writes while shifter busy -> tx_ovf=1, exactly 5 bytes transmitted. Assert resetq low mid-byte -> uart_tx=1 the same cycle.

Source files
------------

// File: rtl/j1_io_uart_pkg.sv
// rtl/j1_io_uart_pkg.sv - shared constants, FSM encodings and helpers for the J1 I/O UART
package j1_io_uart_pkg;

    localparam logic [2:0] OFF_DATA    = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_DIVISOR = 3'd2;
    localparam logic [2:0] OFF_CTRL    = 3'd3;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_NOTFULL  = 1;
    localparam int ST_TX_IDLE     = 2;
    localparam int ST_RX_OVF      = 3;
    localparam int ST_TX_OVF      = 4;
    localparam int ST_FRAME_ERR   = 5;

    localparam int CT_IE_RX    = 0;
    localparam int CT_IE_TX    = 1;
    localparam int CT_LOOPBACK = 2;

    localparam logic [15:0] MIN_DIVISOR = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Very small divisors cannot hold a mid-bit sample point, so clamp.
    function automatic logic [15:0] eff_period(input logic [15:0] div);
        return (div < MIN_DIVISOR) ? MIN_DIVISOR : div;
    endfunction

endpackage

// File: rtl/j1_byte_fifo.sv
// rtl/j1_byte_fifo.sv - small synchronous FIFO; a push is accepted at full when a pop happens in the same cycle
module j1_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/j1_io_uart.sv
// rtl/j1_io_uart.sv - register-mapped 8N1 UART responder on the J1 I/O bus with TX/RX byte FIFOs
module j1_io_uart
    import j1_io_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h1000,
    parameter logic [15:0] CLKDIV     = 16'd434,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] dout,
    output logic [15:0] io_din,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    logic        sel;
    logic [2:0]  offset;
    logic        unused_addr_bit;

    logic [15:0] div_q;
    logic [2:0]  ctrl_q;
    logic        rx_ovf_q, rx_ovf_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        frame_err_q, frame_err_d;

    logic [15:0] period_m1;
    logic [15:0] half_m1;

    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_head;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_head;

    tx_state_e   tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        uart_tx_q;

    rx_state_e   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        rx_in;
    logic        rx_stop_mid;
    logic        frame_err_set;
    logic        tx_idle;

    assign sel             = (mem_addr[15:4] == BASE_ADDR[15:4]);
    assign offset          = mem_addr[3:1];
    assign unused_addr_bit = mem_addr[0];

    assign period_m1 = eff_period(div_q) - 16'd1;
    assign half_m1   = (eff_period(div_q) >> 1) - 16'd1;

    assign tx_push = io_wr & sel & (offset == OFF_DATA);
    assign tx_pop  = ~tx_empty & ((tx_state_q == TX_IDLE) |
                                  ((tx_state_q == TX_STOP) & (tx_cnt_q == '0)));
    assign rx_pop  = io_rd & sel & (offset == OFF_DATA) & ~rx_empty;

    assign rx_stop_mid   = (rx_state_q == RX_STOP) & (rx_cnt_q == '0);
    assign rx_push       = rx_stop_mid & rx_s2_q;
    assign frame_err_set = rx_stop_mid & ~rx_s2_q;

    assign tx_idle = tx_empty & (tx_state_q == TX_IDLE);
    assign uart_tx = uart_tx_q;
    assign rx_in   = ctrl_q[CT_LOOPBACK] ? uart_tx_q : uart_rx;
    assign irq     = (~rx_empty & ctrl_q[CT_IE_RX]) | (tx_empty & ctrl_q[CT_IE_TX]);

    j1_byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .resetq  (resetq),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .data_i  (dout[7:0]),
        .head_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    j1_byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .resetq  (resetq),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .data_i  (rx_shift_q),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    always_comb begin
        io_din = 16'h0000;
        if (sel) begin
            case (offset)
                OFF_DATA:    io_din = rx_empty ? 16'h0000 : {1'b1, 7'b0, rx_head};
                OFF_STATUS:  io_din = {10'b0, frame_err_q, tx_ovf_q, rx_ovf_q,
                                       tx_idle, ~tx_full, ~rx_empty};
                OFF_DIVISOR: io_din = div_q;
                OFF_CTRL:    io_din = {13'b0, ctrl_q};
                default:     io_din = 16'h0000;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
    always_comb begin
        rx_ovf_d    = rx_ovf_q;
        tx_ovf_d    = tx_ovf_q;
        frame_err_d = frame_err_q;
        if (io_wr & sel & (offset == OFF_STATUS)) begin
            if (dout[ST_RX_OVF])    rx_ovf_d    = 1'b0;
            if (dout[ST_TX_OVF])    tx_ovf_d    = 1'b0;
            if (dout[ST_FRAME_ERR]) frame_err_d = 1'b0;
        end
        if (rx_push & rx_full & ~rx_pop) rx_ovf_d    = 1'b1;
        if (tx_push & tx_full & ~tx_pop) tx_ovf_d    = 1'b1;
        if (frame_err_set)               frame_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            div_q       <= CLKDIV;
            ctrl_q      <= 3'b000;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_ovf_q    <= rx_ovf_d;
            tx_ovf_q    <= tx_ovf_d;
            frame_err_q <= frame_err_d;
            if (io_wr & sel & (offset == OFF_DIVISOR)) div_q  <= dout;
            if (io_wr & sel & (offset == OFF_CTRL))    ctrl_q <= dout[2:0];
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            uart_tx_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (!tx_empty) begin
                        tx_shift_q <= tx_head;
                        tx_cnt_q   <= period_m1;
                        uart_tx_q  <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q   <= period_m1;
                        tx_bit_q   <= '0;
                        uart_tx_q  <= tx_shift_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q <= period_m1;
                        if (tx_bit_q == 3'd7) begin
                            uart_tx_q  <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= tx_shift_q >> 1;
                            uart_tx_q  <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == '0) begin
                        if (!tx_empty) begin
                            tx_shift_q <= tx_head;
                            tx_cnt_q   <= period_m1;
                            uart_tx_q  <= 1'b0;
                            tx_state_q <= TX_START;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // Counter is loaded to half a period on the start edge so every later reload lands mid-bit.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_s1_q   <= rx_in;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q & ~rx_s2_q) begin
                        rx_cnt_q   <= half_m1;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == '0) begin
                        if (rx_s2_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_cnt_q   <= period_m1;
                            rx_bit_q   <= '0;
                            rx_state_q <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_cnt_q   <= period_m1;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == '0) rx_state_q <= RX_IDLE;
                    else                rx_cnt_q   <= rx_cnt_q - 16'd1;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_j1_io_uart.sv
// tb/tb_j1_io_uart.sv - directed self-checking bench for j1_io_uart
module tb_j1_io_uart;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] mem_addr = 16'h0000;
    logic [15:0] dout = 16'h0000;
    logic [15:0] io_din;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b1;
    logic [9:0]  tx_frames [$];
    logic [15:0] rd;

    localparam logic [15:0] A_DATA    = 16'h1000;
    localparam logic [15:0] A_STATUS  = 16'h1002;
    localparam logic [15:0] A_DIVISOR = 16'h1004;
    localparam logic [15:0] A_CTRL    = 16'h1006;

    j1_io_uart #(.BASE_ADDR(16'h1000), .CLKDIV(16'd434), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .resetq   (resetq),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .mem_addr (mem_addr),
        .dout     (dout),
        .io_din   (io_din),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        mem_addr = a;
        dout     = d;
        io_wr    = 1'b1;
        @(negedge clk);
        io_wr    = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        mem_addr = a;
        io_rd    = 1'b1;
        #1 d = io_din;
        @(negedge clk);
        io_rd    = 1'b0;
    endtask

    // Drives one 8N1 frame at 8 clocks per bit.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (8) @(negedge clk);
        end
        uart_rx = stop;
        repeat (8) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    // Line monitor for 8 clocks/bit: frame stored as {stop, data[7:0], start}.
    initial begin
        logic [9:0] f;
        forever begin
            @(negedge clk);
            if (mon_en && resetq && uart_tx === 1'b0) begin
                repeat (4) @(negedge clk);
                f[0] = uart_tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (8) @(negedge clk);
                    f[i] = uart_tx;
                end
                tx_frames.push_back(f);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        resetq = 1'b1;

        bus_rd(A_STATUS, rd);      check("reset_status", rd, 16'h0006);
        check("reset_uart_tx", uart_tx, 1'b1);
        check("reset_irq", irq, 1'b0);
        bus_rd(A_DIVISOR, rd);     check("reset_divisor", rd, 16'd434);
        bus_rd(A_CTRL, rd);        check("reset_ctrl", rd, 16'h0000);
        bus_rd(16'h2002, rd);      check("unselected_zero", rd, 16'h0000);
        bus_rd(16'h1008, rd);      check("offset4_zero", rd, 16'h0000);
        @(negedge clk);
        mem_addr = A_STATUS;
        #1 check("comb_read_no_strobe", io_din, 16'h0006);

        bus_wr(A_DIVISOR, 16'd8);
        bus_rd(A_DIVISOR, rd);     check("divisor_rw", rd, 16'd8);
        tx_frames.delete();
        bus_wr(A_DATA, 16'h00A5);
        @(negedge clk);
        check("tx_start_low", uart_tx, 1'b0);
        repeat (90) @(negedge clk);
        check("tx_a5_count", tx_frames.size(), 1);
        if (tx_frames.size() > 0) check("tx_a5_frame", tx_frames[0], {1'b1, 8'hA5, 1'b0});
        bus_rd(A_STATUS, rd);      check("tx_idle_after", rd, 16'h0006);

        bus_wr(A_CTRL, 16'h0004);
        bus_wr(A_DATA, 16'h003C);
        bus_wr(A_DATA, 16'h0081);
        repeat (200) @(negedge clk);
        bus_rd(A_DATA, rd);        check("loop_rd0", rd, 16'h803C);
        bus_rd(A_DATA, rd);        check("loop_rd1", rd, 16'h8081);
        bus_rd(A_DATA, rd);        check("loop_rd_empty", rd, 16'h0000);
        bus_wr(A_CTRL, 16'h0002);
        @(negedge clk);
        check("irq_tx_empty", irq, 1'b1);
        bus_wr(A_CTRL, 16'h0000);

        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        repeat (10) @(negedge clk);
        bus_rd(A_STATUS, rd);      check("rx_ovf_set", rd, 16'h000F);
        bus_wr(A_CTRL, 16'h0001);
        @(negedge clk);
        check("irq_rx", irq, 1'b1);
        bus_wr(A_STATUS, 16'h0008);
        bus_rd(A_STATUS, rd);      check("rx_ovf_clr", rd, 16'h0007);
        bus_rd(A_DATA, rd);        check("rx_byte0", rd, 16'h8011);
        bus_rd(A_DATA, rd);        check("rx_byte1", rd, 16'h8022);
        bus_rd(A_DATA, rd);        check("rx_byte2", rd, 16'h8033);
        bus_rd(A_DATA, rd);        check("rx_byte3", rd, 16'h8044);
        bus_rd(A_DATA, rd);        check("rx_drained", rd, 16'h0000);
        check("irq_rx_clear", irq, 1'b0);
        bus_wr(A_CTRL, 16'h0000);

        send_byte(8'h5A, 1'b0);
        repeat (10) @(negedge clk);
        bus_rd(A_STATUS, rd);      check("frame_err", rd, 16'h0026);
        bus_rd(A_DATA, rd);        check("frame_no_push", rd, 16'h0000);
        bus_wr(A_STATUS, 16'h0020);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        bus_rd(A_STATUS, rd);      check("glitch_ignored", rd, 16'h0006);

        tx_frames.delete();
        bus_wr(A_DATA, 16'h0001);
        repeat (2) @(negedge clk);
        for (int i = 2; i <= 6; i++) bus_wr(A_DATA, 16'(i));
        bus_rd(A_STATUS, rd);      check("tx_ovf_full", rd, 16'h0010);
        repeat (500) @(negedge clk);
        check("tx_frame_count", tx_frames.size(), 5);
        for (int i = 0; i < 5 && i < tx_frames.size(); i++)
            check("tx_ovf_frame", tx_frames[i], {1'b1, 8'(i + 1), 1'b0});
        bus_rd(A_STATUS, rd);      check("tx_ovf_sticky", rd, 16'h0016);
        bus_wr(A_STATUS, 16'h0010);
        bus_rd(A_STATUS, rd);      check("tx_ovf_clr", rd, 16'h0006);

        mon_en = 1'b0;
        bus_wr(A_DATA, 16'h0055);
        repeat (20) @(negedge clk);
        check("mid_byte_low", uart_tx, 1'b0);
        resetq = 1'b0;
        #1 check("async_reset_tx", uart_tx, 1'b1);
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        bus_rd(A_STATUS, rd);      check("post_reset_status", rd, 16'h0006);
        bus_rd(A_DIVISOR, rd);     check("post_reset_divisor", rd, 16'd434);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
